// File: rtl/ecg_pkg.sv
// ecg_pkg: constants and FSM state type shared by the ECG sync pulse
// generator and its phase counter.
//   RX_SAMPLE_INTERVAL : sample interval of the ECG sync receiver, in clk cycles
//   MIN_PHASE_DEFAULT  : shortest legal high or low time, two receiver sample
//                        intervals, so the receiver sees every level at least once
//   ecg_state_t        : generator FSM states (IDLE / HIGH / LOW)
package ecg_pkg;

  localparam int unsigned RX_SAMPLE_INTERVAL = 4096;
  localparam int unsigned MIN_PHASE_DEFAULT  = 2 * RX_SAMPLE_INTERVAL;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HIGH = 2'b01,
    ST_LOW  = 2'b10
  } ecg_state_t;

endpackage

// File: rtl/ecg_phase_cnt.sv
// ecg_phase_cnt: loadable phase counter for the ECG sync generator.
// It compares the count against the latched high time and beat period.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   load                : restart the count at 1 (first cycle of a beat)
//   clr                 : clear the count to 0 (train ended or aborted)
//   inc                 : advance the count by one
//   high_lat            : latched pulse high time
//   period_lat          : latched beat period
//   at_high, at_period  : count equals high_lat / period_lat
module ecg_phase_cnt #(
  parameter int unsigned PERIOD_W = 32,
  parameter int unsigned HIGH_W   = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clr,
  input  logic                inc,
  input  logic [HIGH_W-1:0]   high_lat,
  input  logic [PERIOD_W-1:0] period_lat,
  output logic                at_high,
  output logic                at_period
);

  logic [PERIOD_W-1:0] phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (load) begin
      phase <= PERIOD_W'(1);
    end else if (inc) begin
      phase <= phase + PERIOD_W'(1);
    end
  end

  assign at_high   = (phase == PERIOD_W'(high_lat));
  assign at_period = (phase == period_lat);

endmodule

// File: rtl/ecg_sync_gen.sv
// ecg_sync_gen: synthetic ECG sync pulse generator. It drives a train of
// active-high pulses with a programmable period and high time, either for a
// fixed number of beats or continuously.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : block enable; dropping it aborts any running train
//   start       : one-cycle request to begin a train
//   period_cyc  : beat period in clk cycles (sampled at accepted start)
//   high_cyc    : pulse high time in clk cycles (sampled at accepted start)
//   beats       : number of beats, 0 = continuous (sampled at accepted start)
//   ecg_sync    : generated sync pulse (registered)
//   beat_stb    : one-cycle strobe on each rising edge of ecg_sync
//   beat_cnt    : beats issued in the current train
//   busy        : a train is running
//   done        : one-cycle strobe when a finite train completes
//   cfg_err     : one-cycle strobe when a start is rejected for bad timing
module ecg_sync_gen
  import ecg_pkg::*;
#(
  parameter int unsigned PERIOD_W  = 32,
  parameter int unsigned HIGH_W    = 24,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned MIN_PHASE = MIN_PHASE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic [PERIOD_W-1:0] period_cyc,
  input  logic [HIGH_W-1:0]   high_cyc,
  input  logic [CNT_W-1:0]    beats,
  output logic                ecg_sync,
  output logic                beat_stb,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic                busy,
  output logic                done,
  output logic                cfg_err
);

  ecg_state_t state_q, state_d;

  logic [PERIOD_W-1:0] period_lat;
  logic [HIGH_W-1:0]   high_lat;
  logic [CNT_W-1:0]    beats_lat;

  logic             sync_q, sync_d;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic cfg_load;
  logic ph_load, ph_clr, ph_inc;
  logic at_high, at_period;

  // Timing check is done one bit wider than the period so that a high time
  // longer than the period shows up as a negative low time and is rejected.
  logic [PERIOD_W:0] high_ext;
  logic [PERIOD_W:0] low_diff;
  logic [PERIOD_W:0] min_ext;
  logic              cfg_ok;

  assign high_ext = (PERIOD_W+1)'(high_cyc);
  assign min_ext  = (PERIOD_W+1)'(MIN_PHASE);
  assign low_diff = {1'b0, period_cyc} - high_ext;
  assign cfg_ok   = (high_ext >= min_ext) && !low_diff[PERIOD_W] && (low_diff >= min_ext);

  ecg_phase_cnt #(
    .PERIOD_W (PERIOD_W),
    .HIGH_W   (HIGH_W)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .load       (ph_load),
    .clr        (ph_clr),
    .inc        (ph_inc),
    .high_lat   (high_lat),
    .period_lat (period_lat),
    .at_high    (at_high),
    .at_period  (at_period)
  );

  always_comb begin
    state_d  = state_q;
    sync_d   = sync_q;
    stb_d    = 1'b0;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    cfg_load = 1'b0;
    ph_load  = 1'b0;
    ph_clr   = 1'b0;
    ph_inc   = 1'b0;

    if (!en) begin
      // Abort wins over everything, including a simultaneous start.
      state_d = ST_IDLE;
      sync_d  = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
      ph_clr  = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sync_d = 1'b0;
          busy_d = 1'b0;
          if (start) begin
            if (cfg_ok) begin
              cfg_load = 1'b1;
              ph_load  = 1'b1;
              state_d  = ST_HIGH;
              sync_d   = 1'b1;
              stb_d    = 1'b1;
              cnt_d    = CNT_W'(1);
              busy_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_HIGH: begin
          ph_inc = 1'b1;
          if (at_high) begin
            sync_d  = 1'b0;
            state_d = ST_LOW;
          end
        end
        ST_LOW: begin
          if (at_period) begin
            if ((beats_lat != '0) && (cnt_q == beats_lat)) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
              ph_clr  = 1'b1;
            end else begin
              // Continuous mode relies on the natural wrap of the adder.
              state_d = ST_HIGH;
              sync_d  = 1'b1;
              stb_d   = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
              ph_load = 1'b1;
            end
          end else begin
            ph_inc = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sync_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sync_q  <= 1'b0;
      stb_q   <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_lat <= '0;
      high_lat   <= '0;
      beats_lat  <= '0;
    end else if (cfg_load) begin
      period_lat <= period_cyc;
      high_lat   <= high_cyc;
      beats_lat  <= beats;
    end
  end

  assign ecg_sync = sync_q;
  assign beat_stb = stb_q;
  assign beat_cnt = cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = err_q;

endmodule
